uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmit byte channel among P_REQ_NUM requesters.
- Each requester offers bytes on a valid/ready handshake, with a last flag marking the final byte of a packet.
- Grant is locked for a whole packet, so packets are never interleaved on the line.
- Sits between the user-side producers and the uart_tx byte interface, with a registered output stage toward uart_tx.

Parameters:
- P_REQ_NUM, 4, number of requesters (2..8).
- P_UART_DATA_WIDTH, 8, byte width; matches the UART data width.
- P_TIMEOUT, 255, idle cycles allowed mid-packet before the grant is forcibly released (1..65535).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  P_REQ_NUM  per-requester byte valid.
- i_req_data  input  P_REQ_NUM*P_UART_DATA_WIDTH  per-requester byte; requester k occupies slice [k*W +: W].
- i_req_last  input  P_REQ_NUM  per-requester last-byte-of-packet flag, qualified by valid.
- o_req_ready  output  P_REQ_NUM  per-requester ready; at most one bit high.
- o_tx_data  output  P_UART_DATA_WIDTH  byte to uart_tx.
- o_tx_valid  output  1  byte valid to uart_tx.
- i_tx_ready  input  1  uart_tx can accept a byte.
- o_grant  output  P_REQ_NUM  one-hot current owner; all-zero in S_ARB.
- o_timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset values (asynchronous): state S_ARB, round-robin pointer 0, o_grant 0, o_req_ready 0, o_tx_valid 0, o_tx_data 0, o_timeout 0, idle counter 0.
- Any byte held in the output stage at reset is discarded.

State S_ARB:
- If any i_req_valid bit is set, select the first set index scanning from the pointer upward, wrapping modulo P_REQ_NUM.
- Register the selection into o_grant and move to S_BUSY next cycle.
- If no request, stay in S_ARB.

State S_BUSY:
- For owner g only: o_req_ready[g] = !o_tx_valid || i_tx_ready (combinational). All other ready bits are 0.
- A transfer occurs when i_req_valid[g] && o_req_ready[g]. On transfer, capture the data into o_tx_data and set o_tx_valid the next cycle.
- o_tx_valid clears on i_tx_ready unless a new transfer happens in the same cycle. This gives full throughput: one byte per cycle when uart_tx is always ready.
- Transfer with i_req_last[g]=1:
  - Next state S_ARB; pointer = (g+1) mod P_REQ_NUM; o_grant cleared.
  - The output stage still drains normally; arbitration does not wait for the drain.
- Idle counter:
  - Increments each S_BUSY cycle in which i_req_valid[g]=0, and clears on every transfer.
  - When it reaches P_TIMEOUT: pulse o_timeout for 1 cycle, go to S_ARB, pointer = (g+1) mod P_REQ_NUM, o_grant cleared, counter cleared.
  - Back-pressure (valid=1, ready=0) does not count as idle.

Other rules:
- o_tx_data and o_tx_valid must hold stable while o_tx_valid && !i_tx_ready.
- Valid bits of non-owners are ignored in S_BUSY.
- The arbitration cost is one S_ARB cycle between packets.
- Minimum latency is 2 cycles: request valid in S_ARB, grant in cycle+1 with ready, o_tx_valid in cycle+2.
- A requester that deasserts valid during S_ARB before being registered is simply not granted; no state is retained.
- Single requester: it is re-granted every packet, with one bubble cycle between packets.
- Reset asserted mid-packet: the partial packet is abandoned and the requester must restart the packet.

Test Plan:
- Requester 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), i_tx_ready=1 -> o_tx_valid high 3 consecutive cycles with bytes in order; o_grant=4'b0010 during the packet; returns to S_ARB; pointer=2.
- All four requesters hold 1-byte packets 0xA0..0xA3 continuously from reset -> service order 0,1,2,3,0; each o_grant pulse lasts 1 S_BUSY cycle.
- Requester 0 two-byte packet 0x55,0x66; i_tx_ready low for 5 cycles after the first byte -> o_tx_data holds 0x55 stable; o_req_ready[0]=0 while stalled; 0x66 follows after ready returns; no timeout.
- P_TIMEOUT=4; requester 2 sends 0x01 without last, then drops valid -> o_timeout pulses exactly 4 idle cycles later; o_grant cleared; requester 3 (valid) granted next.
- Requesters 0 and 3 both valid with pointer=1 -> requester 3 granted first, then requester 0.
- i_rst asserted while o_tx_valid=1 mid-packet -> all outputs 0 immediately; after release, a fresh request from requester 0 is granted with pointer 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-channel bundle between the requesters, the arbiter and uart_tx.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the uart_tx sink.
interface uart_tx_arbiter_if #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8
);
  logic [P_REQ_NUM-1:0]                   i_req_valid;
  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data;
  logic [P_REQ_NUM-1:0]                   i_req_last;
  logic [P_REQ_NUM-1:0]                   o_req_ready;
  logic [P_UART_DATA_WIDTH-1:0]           o_tx_data;
  logic                                   o_tx_valid;
  logic                                   i_tx_ready;
  logic [P_REQ_NUM-1:0]                   o_grant;
  logic                                   o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel among P_REQ_NUM
// requesters. A grant is held for a whole packet, which ends on a byte
// flagged last. If the owner goes idle for too long mid-packet, the grant
// is force-released. A one-entry registered output stage feeds uart_tx
// and sustains one byte per cycle when uart_tx is always ready.
module uart_tx_arbiter #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_TIMEOUT         = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
  localparam int W  = P_UART_DATA_WIDTH;
  localparam int CW = 16;

  typedef enum logic {S_ARB, S_BUSY} state_t;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        owner;
  logic [P_REQ_NUM-1:0] grant;
  logic [W-1:0]         tx_data;
  logic                 tx_valid;
  logic                 timeout;
  logic [CW-1:0]        idle_cnt;

  logic [IW-1:0]        sel;
  logic                 sel_found;
  logic                 owner_valid;
  logic                 owner_last;
  logic [W-1:0]         owner_data;
  logic                 owner_ready;
  logic                 xfer;
  logic [P_REQ_NUM-1:0] ready;

  // Successor of a requester index, wrapping modulo P_REQ_NUM.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == P_REQ_NUM - 1) return '0;
    return i + 1'b1;
  endfunction

  // Pick the first valid requester at or above the pointer, with wrap-around.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    int idx;
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    // Scan from the farthest offset down so that the nearest hit wins.
    for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= P_REQ_NUM) idx = idx - P_REQ_NUM;
      if (bus.i_req_valid[idx]) begin
        sel       = IW'(idx);
        sel_found = 1'b1;
      end
    end
  end

  // Owner-side handshake. Ready is combinational, so a stalled output stage
  // blocks the owner within the same cycle.
  always_comb begin
    owner_valid = bus.i_req_valid[owner];
    owner_last  = bus.i_req_last[owner];
    owner_data  = bus.i_req_data[owner*W +: W];
    owner_ready = (state == S_BUSY) && (!tx_valid || bus.i_tx_ready);
    xfer        = owner_ready && owner_valid;
    ready       = '0;
    if (owner_ready) ready[owner] = 1'b1;
  end

  // Arbitration FSM, idle watchdog and output stage, all registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_ARB;
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      timeout  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments, so every
      // register here sees the values from before this clock edge.
      timeout <= 1'b0;

      // The output stage drains in any state, so arbitration never waits for it.
      if (xfer) begin
        tx_data  <= owner_data;
        tx_valid <= 1'b1;
      end else if (bus.i_tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        S_ARB: begin
          if (sel_found) begin
            owner    <= sel;
            grant    <= {{(P_REQ_NUM-1){1'b0}}, 1'b1} << sel;
            idle_cnt <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (owner_last) begin
              ptr   <= next_idx(owner);
              grant <= '0;
              state <= S_ARB;
            end
          end else if (!owner_valid) begin
            // Only a missing owner byte counts as idle; back-pressure does not.
            if (idle_cnt == CW'(P_TIMEOUT - 1)) begin
              timeout  <= 1'b1;
              idle_cnt <= '0;
              ptr      <= next_idx(owner);
              grant    <= '0;
              state    <= S_ARB;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= S_ARB;
      endcase
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_valid  = tx_valid;
  assign bus.o_grant     = grant;
  assign bus.o_timeout   = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are byte queues with
// optional idle gaps. A behavioural model predicts grant, ready, the output
// stage and timeout pulses cycle by cycle. A separate byte-stream scoreboard
// checks the order of bytes that uart_tx accepts.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W)) bus();

  uart_tx_arbiter #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W), .P_TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Driven stimulus.
  logic [N-1:0]   v;
  logic [N*W-1:0] d;
  logic [N-1:0]   l;
  logic           txr;

  assign bus.i_req_valid = v;
  assign bus.i_req_data  = d;
  assign bus.i_req_last  = l;
  assign bus.i_tx_ready  = txr;

  // One byte a requester will offer. gap is the number of idle cycles before it.
  typedef struct {
    logic [7:0] data;
    bit         last;
    int         gap;
  } ent_t;

  ent_t       rq[N][$];
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit         m_busy;
  int         m_own;
  int         m_ptr;
  int         m_idle;
  bit         m_txv;
  bit         m_to;
  logic [7:0] m_txd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    if (m_busy) return N'(1) << m_own;
    return '0;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (m_busy && (!m_txv || txr)) return N'(1) << m_own;
    return '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_idle = 0;
    m_txv = 0; m_to = 0; m_txd = '0;
    exp_q.delete();
    for (int k = 0; k < N; k++) rq[k].delete();
  endtask

  task automatic push(input int k, input logic [7:0] data, input bit last, input int gap);
    ent_t e;
    e.data = data; e.last = last; e.gap = gap;
    rq[k].push_back(e);
  endtask

  // Drive every requester from its queue. In random mode, empty queues are
  // refilled with random packets. txr_mode: 0 random, 1 high, 2 low.
  task automatic drive(input bit rand_mode, input int txr_mode);
    for (int k = 0; k < N; k++) begin
      if (rand_mode && rq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          push(k, 8'($urandom), b == len - 1,
               (b == 0) ? $urandom_range(0, 2)
                        : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0));
      end
      if (rq[k].size() > 0 && rq[k][0].gap == 0) begin
        v[k] = 1'b1;
        d[k*W +: W] = rq[k][0].data;
        l[k] = rq[k][0].last;
      end else begin
        if (rq[k].size() > 0) begin
          ent_t e;
          e = rq[k][0];
          e.gap--;
          rq[k][0] = e;
        end
        v[k] = 1'b0;
        d[k*W +: W] = 8'($urandom);
        l[k] = 1'($urandom);
      end
    end
    case (txr_mode)
      0:       txr = ($urandom_range(0, 3) != 0);
      1:       txr = 1'b1;
      default: txr = 1'b0;
    endcase
  endtask

  // Advance the model by one clock edge from the inputs that were just driven.
  task automatic model_step();
    logic [N-1:0] rdy;
    bit xfer;
    bit found;
    rdy  = exp_ready();
    xfer = m_busy && v[m_own] && rdy[m_own];
    m_to = 0;
    if (xfer) begin
      m_txd = d[m_own*W +: W];
      m_txv = 1;
      exp_q.push_back(m_txd);
      void'(rq[m_own].pop_front());
    end else if (txr) begin
      m_txv = 0;
    end
    if (!m_busy) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && v[(m_ptr + i) % N]) begin
          found = 1;
          m_own = (m_ptr + i) % N;
          m_busy = 1;
          m_idle = 0;
        end
      end
    end else if (xfer) begin
      m_idle = 0;
      if (l[m_own]) begin
        m_busy = 0;
        m_ptr = (m_own + 1) % N;
      end
    end else if (!v[m_own]) begin
      m_idle++;
      if (m_idle == TO) begin
        m_to = 1;
        m_busy = 0;
        m_ptr = (m_own + 1) % N;
        m_idle = 0;
      end
    end
  endtask

  // One clock cycle: check registered outputs, drive, check ready and the
  // accepted byte stream, then step the model.
  task automatic step(input bit rand_mode, input int txr_mode);
    @(negedge clk);
    check("grant",    32'(bus.o_grant),    32'(exp_grant()));
    check("tx_valid", 32'(bus.o_tx_valid), 32'(m_txv));
    check("tx_data",  32'(bus.o_tx_data),  32'(m_txd));
    check("timeout",  32'(bus.o_timeout),  32'(m_to));
    drive(rand_mode, txr_mode);
    #1;
    check("ready", 32'(bus.o_req_ready), 32'(exp_ready()));
    if (bus.o_tx_valid && txr) begin
      check("stream_avail", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) check("stream_data", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    model_step();
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 0;
    return !m_busy && !m_txv && exp_q.size() == 0;
  endfunction

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (!all_idle() && budget < 300) begin
      step(0, 1);
      budget++;
    end
    check(tag, 32'(all_idle()), 32'(1));
  endtask

  initial begin
    int to_seen;
    logic [N-1:0] first_grant;
    int budget;

    rst = 1'b1;
    v = '0; d = '0; l = '0; txr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_grant",    32'(bus.o_grant),     32'(0));
    check("rst_ready",    32'(bus.o_req_ready), 32'(0));
    check("rst_tx_valid", 32'(bus.o_tx_valid),  32'(0));
    check("rst_tx_data",  32'(bus.o_tx_data),   32'(0));
    check("rst_timeout",  32'(bus.o_timeout),   32'(0));
    rst = 1'b0;

    // Requester 1 sends a three-byte packet.
    push(1, 8'h11, 0, 0); push(1, 8'h22, 0, 0); push(1, 8'h33, 1, 0);
    drain("drain_pkt3");

    // All four requesters hold one-byte packets continuously.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, 8'hA0 + 8'(k), 1, 0);
    drain("drain_all4");

    // Requester 0 two-byte packet with uart_tx stalled for 5 cycles after byte one.
    push(0, 8'h55, 0, 0); push(0, 8'h66, 1, 0);
    budget = 0;
    while (!m_txv && budget < 20) begin step(0, 1); budget++; end
    check("stall_first_byte", 32'(m_txv), 32'(1));
    repeat (5) step(0, 2);
    drain("drain_stall");

    // Requester 2 sends one byte without last and goes silent, while requester 3 waits.
    push(2, 8'h01, 0, 0);
    push(3, 8'h77, 1, 0);
    to_seen = 0;
    budget = 0;
    while (!all_idle() && budget < 50) begin
      step(0, 1);
      if (bus.o_timeout) to_seen++;
      budget++;
    end
    check("timeout_pulses", 32'(to_seen), 32'(1));
    check("drain_timeout", 32'(all_idle()), 32'(1));

    // Move the pointer to 1, then requesters 0 and 3 compete: 3 goes first.
    push(0, 8'h10, 1, 0);
    drain("drain_ptr1");
    push(0, 8'h20, 1, 0); push(3, 8'h30, 1, 0);
    first_grant = '0;
    budget = 0;
    while (!all_idle() && budget < 50) begin
      step(0, 1);
      if (first_grant == '0) first_grant = bus.o_grant;
      budget++;
    end
    check("first_grant_rr", 32'(first_grant), 32'(4'b1000));

    // Randomized traffic with random uart_tx back-pressure.
    repeat (1500) step(1, 0);
    drain("drain_random");

    // Reset while a byte is held in the output stage.
    budget = 0;
    while (!(m_busy && m_txv) && budget < 500) begin step(1, 0); budget++; end
    check("reset_setup", 32'(m_busy && m_txv), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_grant",    32'(bus.o_grant),     32'(0));
    check("mid_rst_ready",    32'(bus.o_req_ready), 32'(0));
    check("mid_rst_tx_valid", 32'(bus.o_tx_valid),  32'(0));
    check("mid_rst_tx_data",  32'(bus.o_tx_data),   32'(0));
    check("mid_rst_timeout",  32'(bus.o_timeout),   32'(0));
    v = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(0, 8'h5A, 1, 0);
    drain("drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
